// File: rtl/sw_debounce_reader.sv
// rtl/sw_debounce_reader.sv - synchronise, debounce and hand off a switch word with valid/ack
// Optional overrun flag compiled in by defining SW_READER_OVERRUN_EN.
module sw_debounce_reader #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic             iCLK,
   input  logic             iRST_N,
   input  logic [WIDTH-1:0] iSW,
   input  logic             iACK,
   output logic [WIDTH-1:0] oDATA,
   output logic [WIDTH-1:0] oCHANGED,
   output logic             oVALID,
   output logic             oOVERRUN
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {STABLE, SETTLE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] s1_q, s2_q;
   logic [WIDTH-1:0] cand_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [WIDTH-1:0] data_q, changed_q;
   logic             valid_q;
   logic             window_done;
   logic             commit;

   assign cnt_d       = cnt_q + 1'b1;
   assign window_done = (state_q == SETTLE) && (s2_q == cand_q) && (cnt_q == CNT_LAST);
   // A window that expires on the already-published word is a bounce-back, not an event.
   assign commit      = window_done && (cand_q != data_q);

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         s1_q      <= '0;
         s2_q      <= '0;
         cand_q    <= '0;
         cnt_q     <= '0;
         state_q   <= STABLE;
         data_q    <= '0;
         changed_q <= '0;
         valid_q   <= 1'b0;
      end else begin
         s1_q <= iSW;
         s2_q <= s1_q;

         case (state_q)
            STABLE: begin
               if (s2_q != data_q) begin
                  cand_q  <= s2_q;
                  cnt_q   <= '0;
                  state_q <= SETTLE;
               end
            end
            SETTLE: begin
               if (s2_q != cand_q) begin
                  cand_q <= s2_q;
                  cnt_q  <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= STABLE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: state_q <= STABLE;
         endcase

         if (commit) begin
            data_q    <= cand_q;
            changed_q <= cand_q ^ data_q;
            valid_q   <= 1'b1;
         end else if (iACK) begin
            valid_q <= 1'b0;
         end
      end
   end

`ifdef SW_READER_OVERRUN_EN
   logic overrun_q;

   // A commit racing an acknowledge is a clean hand-off, so it never flags.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         overrun_q <= 1'b0;
      end else if (commit) begin
         overrun_q <= valid_q && !iACK;
      end else if (iACK) begin
         overrun_q <= 1'b0;
      end
   end

   assign oOVERRUN = overrun_q;
`else
   assign oOVERRUN = 1'b0;
`endif

   assign oDATA    = data_q;
   assign oCHANGED = changed_q;
   assign oVALID   = valid_q;

endmodule

// File: tb/tb_sw_debounce_reader.sv
// tb/tb_sw_debounce_reader.sv - scoreboard bench for sw_debounce_reader (WIDTH=8, DEBOUNCE_CYCLES=4)
module tb_sw_debounce_reader;

   localparam int W = 8;
   localparam int DC = 4;
`ifdef SW_READER_OVERRUN_EN
   localparam bit OVR_EN = 1'b1;
`else
   localparam bit OVR_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] sw = '0;
   logic         ack = 1'b0;
   logic [W-1:0] o_data, o_changed;
   logic         o_valid, o_overrun;

   typedef struct {
      logic [W-1:0] data;
      logic [W-1:0] changed;
      logic         ovr;
      int           edge_no;
   } exp_t;

   exp_t   sb[$];
   int     total = 0;
   int     bad = 0;
   int     edges = 0;
   logic [W-1:0] prev_data = '0;

   sw_debounce_reader #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
      .iCLK(clk), .iRST_N(rst_n), .iSW(sw), .iACK(ack),
      .oDATA(o_data), .oCHANGED(o_changed), .oVALID(o_valid), .oOVERRUN(o_overrun)
   );

   always #10 clk = ~clk;
   always @(posedge clk) edges++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Every commit changes oDATA, so a change of oDATA out of reset marks one DUT event.
   always @(negedge clk) begin
      if (rst_n && o_data !== prev_data) begin
         if (sb.size() == 0) begin
            chk("unexpected_commit", {24'd0, o_data}, {24'd0, prev_data});
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("commit_data", {24'd0, o_data}, {24'd0, e.data});
            chk("commit_changed", {24'd0, o_changed}, {24'd0, e.changed});
            chk("commit_valid", {31'd0, o_valid}, 32'd1);
            chk("commit_overrun", {31'd0, o_overrun}, {31'd0, e.ovr});
            chk("commit_edge", edges, e.edge_no);
         end
      end
      prev_data = o_data;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive a new switch word and queue its commit, 7 edges from now.
   task automatic set_sw(input logic [W-1:0] v, input logic [W-1:0] chg, input logic ovr);
      exp_t e;
      sw = v;
      e.data = v;
      e.changed = chg;
      e.ovr = ovr & OVR_EN;
      e.edge_no = edges + DC + 3;
      sb.push_back(e);
   endtask

   task automatic drain();
      int budget = 40;
      while (sb.size() != 0 && budget > 0) begin
         @(negedge clk);
         #2;
         budget--;
      end
      chk("drain_timeout", sb.size(), 0);
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      cyc(1);
      ack = 1'b0;
   endtask

   initial begin
      sw = 8'hFF;
      cyc(4);
      chk("rst_data", {24'd0, o_data}, 32'h0);
      chk("rst_changed", {24'd0, o_changed}, 32'h0);
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_overrun", {31'd0, o_overrun}, 32'd0);

      rst_n = 1'b1;
      set_sw(8'hFF, 8'hFF, 1'b0);
      drain();
      pulse_ack();
      chk("ack_valid", {31'd0, o_valid}, 32'd0);
      chk("ack_data_hold", {24'd0, o_data}, 32'hFF);

      set_sw(8'h00, 8'hFF, 1'b0);
      drain();
      pulse_ack();
      set_sw(8'h3C, 8'h3C, 1'b0);
      drain();
      pulse_ack();
      chk("ack2_valid", {31'd0, o_valid}, 32'd0);
      chk("ack2_data", {24'd0, o_data}, 32'h3C);

      set_sw(8'h00, 8'h3C, 1'b0);
      drain();
      pulse_ack();
      for (int i = 0; i < 10; i++) begin
         sw = (i % 2 == 0) ? 8'h01 : 8'h00;
         cyc(2);
      end
      chk("bounce_no_valid", {31'd0, o_valid}, 32'd0);
      set_sw(8'h01, 8'h01, 1'b0);
      drain();
      pulse_ack();

      set_sw(8'h00, 8'h01, 1'b0);
      drain();
      pulse_ack();
      sw = 8'h80;
      cyc(2);
      sw = 8'h00;
      cyc(12);
      chk("bounceback_valid", {31'd0, o_valid}, 32'd0);
      chk("bounceback_data", {24'd0, o_data}, 32'h00);

      set_sw(8'h0F, 8'h0F, 1'b0);
      drain();
      set_sw(8'hF0, 8'hFF, 1'b1);
      drain();
      chk("overrun_set", {31'd0, o_overrun}, {31'd0, OVR_EN});

      set_sw(8'hAA, 8'h5A, 1'b0);
      cyc(DC + 2);
      ack = 1'b1;
      cyc(1);
      ack = 1'b0;
      drain();
      chk("simul_valid", {31'd0, o_valid}, 32'd1);
      chk("simul_overrun", {31'd0, o_overrun}, 32'd0);
      pulse_ack();
      chk("final_ack_valid", {31'd0, o_valid}, 32'd0);

      sw = 8'h55;
      cyc(5);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_data", {24'd0, o_data}, 32'h0);
      chk("async_rst_changed", {24'd0, o_changed}, 32'h0);
      chk("async_rst_valid", {31'd0, o_valid}, 32'd0);
      sw = 8'h00;
      cyc(3);
      rst_n = 1'b1;
      cyc(15);
      chk("post_rst_valid", {31'd0, o_valid}, 32'd0);
      chk("post_rst_data", {24'd0, o_data}, 32'h0);
      chk("sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
